// File: rtl/mux_pingpong_feed_if.sv
// Handshake and operand bus between the ping-pong feed, its producer and the downstream two-input mux.
// The slave modport is the buffer's view. The master modport is the view of the producer/consumer side.
interface mux_pingpong_feed_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, a, b, s, out_valid, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, a, b, s, out_valid, count
  );
endinterface

// File: rtl/mux_pingpong_feed.sv
// Two-slot ping-pong buffer feeding a 2:1 mux (out = s ? a : b), forming a 2-deep FIFO. A push appears on a/b after one edge.
// in_ready deasserts whenever two words are held, with no pass-through on pop; out_ready is ignored while empty.
module mux_pingpong_feed #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  mux_pingpong_feed_if.slave bus
);

  logic [WIDTH-1:0] slot_a;
  logic [WIDTH-1:0] slot_b;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  // Handshake qualifiers come from registered state only, so a full buffer stays closed even while popping.
  assign push = bus.in_valid && (cnt != 2'd2);
  assign pop  = bus.out_ready && (cnt != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_a <= '0;
      slot_b <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) slot_b <= bus.in_data;
        else        slot_a <= bus.in_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.a         = slot_a;
  assign bus.b         = slot_b;
  assign bus.s         = ~rd_ptr;
  assign bus.in_ready  = (cnt != 2'd2);
  assign bus.out_valid = (cnt != 2'd0);
  assign bus.count     = cnt;

  // The pointers always differ by the occupancy parity.
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt != 2'd3);
  a_ptr_sync:  assert property (@(posedge clk) disable iff (!rst_n) wr_ptr == (rd_ptr ^ cnt[0]));

endmodule

// File: tb/tb_mux_pingpong_feed.sv
// Directed vector table for the ping-pong mux feed, followed by a full-hold and drain sequence.
module tb_mux_pingpong_feed;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mux_pingpong_feed_if #(.WIDTH(32)) bus ();

  mux_pingpong_feed #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mux_out;
  assign mux_out = bus.s ? bus.a : bus.b;

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        chk;
    logic [1:0]  cnt;
    logic        ir;
    logic        ov;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] o;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic iv, input logic [31:0] d, input logic ordy,
                     input logic chk, input logic [1:0] cnt, input logic ir, input logic ov,
                     input logic s, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.rst_n = r; v.iv = iv; v.d = d; v.ordy = ordy; v.chk = chk;
    v.cnt = cnt; v.ir = ir; v.ov = ov; v.s = s; v.a = a; v.b = b;
    v.o = s ? a : b;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [31:0] got[$];
    int          cyc;
    n_checks     = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.out_ready = 1'b0;

    //  rst iv data          ordy chk cnt ir ov s  a             b
    // Reset then idle
    add(0, 0, 32'h0,         0,   0,  0,  1, 0, 1, 32'h0,        32'h0);
    add(0, 0, 32'h0,         0,   1,  0,  1, 0, 1, 32'h0,        32'h0);
    add(1, 0, 32'h0,         0,   1,  0,  1, 0, 1, 32'h0,        32'h0);
    // Single word in and out
    add(1, 1, 32'haaaaaaaa,  0,   1,  0,  1, 0, 1, 32'h0,        32'h0);
    add(1, 0, 32'h0,         1,   1,  1,  1, 1, 1, 32'haaaaaaaa, 32'h0);
    add(1, 0, 32'h0,         0,   1,  0,  1, 0, 0, 32'haaaaaaaa, 32'h0);
    // Reset clears slots, then fill, refuse a third, drain, pop empty
    add(0, 0, 32'h0,         0,   1,  0,  1, 0, 0, 32'haaaaaaaa, 32'h0);
    add(1, 1, 32'haaaaaaaa,  0,   1,  0,  1, 0, 1, 32'h0,        32'h0);
    add(1, 1, 32'hcccccccc,  0,   1,  1,  1, 1, 1, 32'haaaaaaaa, 32'h0);
    add(1, 1, 32'h12345678,  0,   1,  2,  0, 1, 1, 32'haaaaaaaa, 32'hcccccccc);
    add(1, 0, 32'h0,         1,   1,  2,  0, 1, 1, 32'haaaaaaaa, 32'hcccccccc);
    add(1, 0, 32'h0,         1,   1,  1,  1, 1, 0, 32'haaaaaaaa, 32'hcccccccc);
    add(1, 0, 32'h0,         1,   1,  0,  1, 0, 1, 32'haaaaaaaa, 32'hcccccccc);
    // Full plus pop: only the pop happens
    add(1, 1, 32'h11111111,  0,   1,  0,  1, 0, 1, 32'haaaaaaaa, 32'hcccccccc);
    add(1, 1, 32'h22222222,  0,   1,  1,  1, 1, 1, 32'h11111111, 32'hcccccccc);
    add(1, 1, 32'h33333333,  1,   1,  2,  0, 1, 1, 32'h11111111, 32'h22222222);
    add(1, 0, 32'h0,         0,   1,  1,  1, 1, 0, 32'h11111111, 32'h22222222);
    // Streaming 1..8 with count held at 1
    add(1, 1, 32'h1,         1,   1,  1,  1, 1, 0, 32'h11111111, 32'h22222222);
    add(1, 1, 32'h2,         1,   1,  1,  1, 1, 1, 32'h1,        32'h22222222);
    add(1, 1, 32'h3,         1,   1,  1,  1, 1, 0, 32'h1,        32'h2);
    add(1, 1, 32'h4,         1,   1,  1,  1, 1, 1, 32'h3,        32'h2);
    add(1, 1, 32'h5,         1,   1,  1,  1, 1, 0, 32'h3,        32'h4);
    add(1, 1, 32'h6,         1,   1,  1,  1, 1, 1, 32'h5,        32'h4);
    add(1, 1, 32'h7,         1,   1,  1,  1, 1, 0, 32'h5,        32'h6);
    add(1, 1, 32'h8,         1,   1,  1,  1, 1, 1, 32'h7,        32'h6);
    add(1, 1, 32'h9,         0,   1,  1,  1, 1, 0, 32'h7,        32'h8);
    // Reset mid-stream while pushing and popping
    add(0, 1, 32'hdeadbeef,  1,   1,  2,  0, 1, 0, 32'h9,        32'h8);
    add(1, 1, 32'h55555555,  0,   1,  0,  1, 0, 1, 32'h0,        32'h0);
    add(1, 0, 32'h0,         0,   1,  1,  1, 1, 1, 32'h55555555, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n         = vecs[i].rst_n;
      bus.in_valid  = vecs[i].iv;
      bus.in_data   = vecs[i].d;
      bus.out_ready = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        check("count",     i, {30'b0, bus.count}, {30'b0, vecs[i].cnt});
        check("in_ready",  i, {31'b0, bus.in_ready}, {31'b0, vecs[i].ir});
        check("out_valid", i, {31'b0, bus.out_valid}, {31'b0, vecs[i].ov});
        check("s",         i, {31'b0, bus.s}, {31'b0, vecs[i].s});
        check("a",         i, bus.a, vecs[i].a);
        check("b",         i, bus.b, vecs[i].b);
        check("mux_out",   i, mux_out, vecs[i].o);
      end
      @(posedge clk);
    end

    // Buffer holds 5555 in A; fill B, then hold a refused push for several cycles.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h000000a1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_data = 32'h000000b2 + k;
      #1;
      check("hold_count", 100 + k, {30'b0, bus.count}, 32'd2);
      check("hold_ready", 100 + k, {31'b0, bus.in_ready}, 32'd0);
      check("hold_a",     100 + k, bus.a, 32'h55555555);
      check("hold_b",     100 + k, bus.b, 32'h000000a1);
      @(posedge clk);
    end

    // Drain with a bounded wait and confirm arrival order.
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (cyc < 6) begin
      #1;
      if (!bus.out_valid) break;
      got.push_back(mux_out);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("drain_timeout", 200, {31'b0, bus.out_valid}, 32'd0);
    check("drain_size",    200, got.size(), 32'd2);
    check("drain_first",   200, (got.size() > 0) ? got[0] : 32'hx, 32'h55555555);
    check("drain_second",  200, (got.size() > 1) ? got[1] : 32'hx, 32'h000000a1);
    check("drain_count",   200, {30'b0, bus.count}, 32'd0);
    bus.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
